// File: rtl/write_buffer_nway.sv
// Multi-entry eviction write buffer between L2 and memory: FIFO of dirty lines with
// write coalescing, read-miss forwarding and a strobe/ack drain to memory.
module write_buffer_nway #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         w_req,
    input  logic [ADDR_W-1:0]            w_address,
    input  logic [LINE_W-1:0]            wdata,
    output logic                         w_ack,
    input  logic [ADDR_W-1:0]            r_address,
    output logic                         r_hit,
    output logic [LINE_W-1:0]            r_data,
    output logic                         mem_stb,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_adr,
    output logic [LINE_W-1:0]            mem_dat,
    input  logic                         mem_ack,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [DEPTH-1:0]   valid_reg;
    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [LINE_W-1:0]  data_mem [DEPTH];
    logic [PTR_W-1:0]   head_reg, tail_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [0:0]         state_reg;
    logic               w_ack_reg, mem_stb_reg;
    logic [ADDR_W-1:0]  mem_adr_reg;
    logic [LINE_W-1:0]  mem_dat_reg;

    logic [DEPTH-1:0]   w_match, r_match;
    logic               in_flight, accept, co_hit;
    logic [PTR_W-1:0]   co_idx, fwd_idx;
    logic               do_coalesce, do_alloc, do_pop, do_start;
    logic [LINE_W-1:0]  head_dat_next;

    assign in_flight = (state_reg == ST_XFER);

    // The head being transferred is excluded from coalescing so memory sees a stable line.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_match[gi] = valid_reg[gi] && (addr_mem[gi] == w_address) &&
                                 !(in_flight && (head_reg == PTR_W'(gi)));
            assign r_match[gi] = valid_reg[gi] && (addr_mem[gi] == r_address);
        end
    endgenerate

    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                co_hit = 1'b1;
                co_idx = PTR_W'(i);
            end
        end
    end

    assign accept      = w_req && !w_ack_reg;
    assign do_coalesce = accept && co_hit;
    assign do_alloc    = accept && !co_hit && (count_reg != CNT_FULL);
    assign do_pop      = in_flight && mem_ack;
    assign do_start    = !in_flight && (count_reg != '0);

    // A coalesce into the head on the edge the transfer starts must reach memory.
    assign head_dat_next = (do_coalesce && (co_idx == head_reg)) ? wdata : data_mem[head_reg];

    // Walk oldest to newest so the last match is the one closest to tail.
    always_comb begin
        r_hit   = 1'b0;
        r_data  = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PTR_W'(k);
            if (r_match[fwd_idx]) begin
                r_hit  = 1'b1;
                r_data = data_mem[fwd_idx];
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        if (do_alloc && !do_pop)
            count_next = count_reg + CNT_W'(1);
        else if (!do_alloc && do_pop)
            count_next = count_reg - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if ((do_alloc && (tail_reg == PTR_W'(i))) || (do_coalesce && (co_idx == PTR_W'(i)))) begin
                addr_mem[i] <= w_address;
                data_mem[i] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            state_reg   <= ST_IDLE;
            w_ack_reg   <= 1'b0;
            mem_stb_reg <= 1'b0;
            mem_adr_reg <= '0;
            mem_dat_reg <= '0;
        end else begin
            w_ack_reg <= do_coalesce || do_alloc;
            count_reg <= count_next;
            if (do_alloc) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            if (do_pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
                state_reg           <= ST_IDLE;
                mem_stb_reg         <= 1'b0;
            end else if (do_start) begin
                state_reg   <= ST_XFER;
                mem_stb_reg <= 1'b1;
                mem_adr_reg <= addr_mem[head_reg];
                mem_dat_reg <= head_dat_next;
            end
        end
    end

    assign w_ack   = w_ack_reg;
    assign mem_stb = mem_stb_reg;
    assign mem_we  = mem_stb_reg;
    assign mem_adr = mem_adr_reg;
    assign mem_dat = mem_dat_reg;
    assign count   = count_reg;
    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);

endmodule

// File: tb/tb_write_buffer_nway.sv
// Randomized bench for write_buffer_nway against a queue-based model of the buffer.
module tb_write_buffer_nway;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              w_req = 1'b0;
    logic [ADDR_W-1:0] w_address = '0;
    logic [LINE_W-1:0] wdata = '0;
    logic              w_ack;
    logic [ADDR_W-1:0] r_address = '0;
    logic              r_hit;
    logic [LINE_W-1:0] r_data;
    logic              mem_stb, mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [LINE_W-1:0] mem_dat;
    logic              mem_ack = 1'b0;
    logic              full, empty;
    logic [CNT_W-1:0]  count;

    write_buffer_nway #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n), .w_req(w_req), .w_address(w_address), .wdata(wdata),
        .w_ack(w_ack), .r_address(r_address), .r_hit(r_hit), .r_data(r_data),
        .mem_stb(mem_stb), .mem_we(mem_we), .mem_adr(mem_adr), .mem_dat(mem_dat),
        .mem_ack(mem_ack), .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
    } ent_t;

    ent_t q[$];        // queued lines, oldest first; q[0] is on the bus when m_xfer
    bit   m_xfer = 0;
    bit   m_ack  = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Applies one clock edge to the model using the inputs that were stable before it.
    task automatic model_edge();
        int pre_n = q.size();
        bit pop   = m_xfer && mem_ack;
        bit nack  = 0;
        if (w_req && !m_ack) begin
            int hit = -1;
            for (int j = (m_xfer ? 1 : 0); j < q.size(); j++)
                if (q[j].a == w_address) hit = j;
            if (hit >= 0) begin
                q[hit].d = wdata;
                nack = 1;
                $display("[%0t] coalesce addr=%0h", $time, w_address);
            end else if (pre_n < DEPTH) begin
                q.push_back('{w_address, wdata});
                nack = 1;
                $display("[%0t] allocate addr=%0h", $time, w_address);
            end
        end
        if (pop) begin
            $display("[%0t] mem write addr=%0h", $time, q[0].a);
            void'(q.pop_front());
            m_xfer = 0;
        end else if (!m_xfer && pre_n > 0) begin
            m_xfer = 1;
        end
        m_ack = nack;
    endtask

    task automatic compare_all();
        bit                exp_hit = 0;
        logic [LINE_W-1:0] exp_dat = '0;
        check("w_ack",   w_ack,   m_ack);
        check("count",   count,   q.size());
        check("full",    full,    q.size() == DEPTH);
        check("empty",   empty,   q.size() == 0);
        check("mem_stb", mem_stb, m_xfer);
        check("mem_we",  mem_we,  m_xfer);
        if (m_xfer) begin
            check("mem_adr", mem_adr, q[0].a);
            check("mem_dat", mem_dat, q[0].d);
        end
        foreach (q[j]) begin
            if (q[j].a == r_address) begin
                exp_hit = 1;
                exp_dat = q[j].d;
            end
        end
        check("r_hit",  r_hit,  exp_hit);
        check("r_data", r_data, exp_dat);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input int ack_pct);
        if (w_req && m_ack) w_req = 1'b0;
        if (!w_req && $urandom_range(0, 3) != 0) begin
            w_req     = 1'b1;
            w_address = 32'h100 * $urandom_range(1, 6);
            wdata     = rand_line();
        end
        mem_ack   = m_xfer ? ($urandom_range(0, 99) < ack_pct) : ($urandom_range(0, 9) == 0);
        r_address = 32'h100 * $urandom_range(1, 9);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stb"},   mem_stb, 1'b0);
        check({tag, "_count"}, count,   '0);
        check({tag, "_empty"}, empty,   1'b1);
        check({tag, "_full"},  full,    1'b0);
        check({tag, "_ack"},   w_ack,   1'b0);
        check({tag, "_adr"},   mem_adr, '0);
        check({tag, "_dat"},   mem_dat, '0);
    endtask

    initial begin
        bit found;
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int c = 0; c < 1500; c++) begin
            drive(c < 500 ? 15 : (c < 1000 ? 50 : 85));
            tick();
        end

        // Reset in the middle of a transfer, then a stray ack.
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (m_xfer) found = 1;
            else begin
                drive(0);
                tick();
            end
        end
        check("xfer_seen", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_xfer = 0;
        m_ack  = 0;
        check_reset_outputs("rst_mid");
        w_req   = 1'b0;
        mem_ack = 1'b1;
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("late_ack_count", count, '0);
        mem_ack = 1'b0;

        for (int c = 0; c < 300; c++) begin
            drive(40);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
